// File: rtl/piezo_tone_gen.sv
// piezo_tone_gen
//   Turns a play request and a half-period limit (clk cycles per half wave)
//   into a glitch-free square wave for the piezo. Pitch changes land only on
//   half-period boundaries, distinct notes can be separated by a silent gap
//   counted in i_tick periods, and stopping always leaves the output low.
// Ports
//   clk           system clock
//   rst           synchronous reset, active high
//   i_tick        1 ms strobe, one clk wide
//   i_play_en     tone request
//   i_pitch       half-period limit in cycles, 0 = silence
//   o_piezo       square wave out
//   o_busy        high whenever the FSM is not idle
//   o_note_start  one-cycle pulse after each note entry into RUN
module piezo_tone_gen #(
  parameter int unsigned MIN_HALF = 1000,
  parameter int unsigned MAX_HALF = 2500000,
  parameter int unsigned GAP_MS   = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_tick,
  input  logic        i_play_en,
  input  logic [31:0] i_pitch,
  output logic        o_piezo,
  output logic        o_busy,
  output logic        o_note_start
);

  typedef enum logic [1:0] {IDLE, RUN, STOP_PEND, GAP} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] limit_q, limit_d;
  logic [31:0] gap_cnt_q, gap_cnt_d;
  logic        piezo_q, piezo_d;
  logic        note_q, note_d;

  logic [31:0] eff_pitch;
  logic        req;
  logic        boundary;

  always_comb begin
    if (i_pitch == 32'd0)         eff_pitch = 32'd0;
    else if (i_pitch < MIN_HALF)  eff_pitch = MIN_HALF;
    else if (i_pitch > MAX_HALF)  eff_pitch = MAX_HALF;
    else                          eff_pitch = i_pitch;
  end

  assign req      = i_play_en && (eff_pitch != 32'd0);
  // limit_q is only compared while it holds a clamped pitch (>= MIN_HALF >= 2)
  assign boundary = (cnt_q == limit_q - 32'd1);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    limit_d   = limit_q;
    gap_cnt_d = gap_cnt_q;
    piezo_d   = piezo_q;
    note_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d   = 32'd0;
        piezo_d = 1'b0;
        if (req) begin
          state_d = RUN;
          limit_d = eff_pitch;
          note_d  = 1'b1;
        end
      end
      // A returning request in STOP_PEND resumes RUN in the same cycle so the
      // phase carries on untouched; it is a resume, not a new note.
      RUN, STOP_PEND: begin
        if (req) begin
          state_d = RUN;
          cnt_d   = cnt_q + 32'd1;
          if (boundary) begin
            cnt_d = 32'd0;
            if (eff_pitch != limit_q && GAP_MS != 0) begin
              // distinct note: silence first, never toggle high here
              piezo_d   = 1'b0;
              gap_cnt_d = 32'd0;
              state_d   = GAP;
            end else begin
              limit_d = eff_pitch;
              piezo_d = ~piezo_q;
            end
          end
        end else if (!piezo_q) begin
          state_d = IDLE;
          cnt_d   = 32'd0;
        end else if (boundary) begin
          // high half completes on this edge: fall and go idle directly
          piezo_d = 1'b0;
          cnt_d   = 32'd0;
          state_d = IDLE;
        end else begin
          state_d = STOP_PEND;
          cnt_d   = cnt_q + 32'd1;
        end
      end
      GAP: begin
        cnt_d   = 32'd0;
        piezo_d = 1'b0;
        if (!req) begin
          state_d = IDLE;
        end else if (i_tick) begin
          if (gap_cnt_q == GAP_MS - 32'd1) begin
            state_d   = RUN;
            limit_d   = eff_pitch;
            note_d    = 1'b1;
            gap_cnt_d = 32'd0;
          end else begin
            gap_cnt_d = gap_cnt_q + 32'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 32'd0;
      limit_q   <= 32'd0;
      gap_cnt_q <= 32'd0;
      piezo_q   <= 1'b0;
      note_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      limit_q   <= limit_d;
      gap_cnt_q <= gap_cnt_d;
      piezo_q   <= piezo_d;
      note_q    <= note_d;
    end
  end

  assign o_piezo      = piezo_q;
  assign o_busy       = (state_q != IDLE);
  assign o_note_start = note_q;

endmodule

// File: tb/tb_piezo_tone_gen.sv
// Bench for piezo_tone_gen: two instances share stimulus, one with GAP_MS=0
// (id 0) and one with GAP_MS=2 (id 1). Half-periods are scaled down
// (MIN_HALF=8, MAX_HALF=300) and i_tick fires every 40 cycles. Expected
// note-start pulses and piezo edges are queued with their cycle number; a
// negedge monitor pops and compares each event the DUTs actually present.
module tb_piezo_tone_gen;

  localparam int TICK_P = 40;

  logic        clk = 1'b0;
  logic        rst;
  logic        tick;
  logic        play;
  logic [31:0] pitch;
  logic [1:0]  pz, busy, ns;
  logic [1:0]  prev = 2'b00;
  logic        mon_en = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {int id; int kind; int cyc;} evt_t;
  evt_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  piezo_tone_gen #(.MIN_HALF(8), .MAX_HALF(300), .GAP_MS(0)) u_g0 (
    .clk(clk), .rst(rst), .i_tick(tick), .i_play_en(play), .i_pitch(pitch),
    .o_piezo(pz[0]), .o_busy(busy[0]), .o_note_start(ns[0]));

  piezo_tone_gen #(.MIN_HALF(8), .MAX_HALF(300), .GAP_MS(2)) u_g2 (
    .clk(clk), .rst(rst), .i_tick(tick), .i_play_en(play), .i_pitch(pitch),
    .o_piezo(pz[1]), .o_busy(busy[1]), .o_note_start(ns[1]));

  // tick is sampled at posedges where cyc+1 is 1 mod TICK_P
  initial begin
    tick = 1'b0;
    forever begin
      @(posedge clk); #1;
      tick = (cyc % TICK_P == 0);
    end
  end

  task automatic push(input int id, input int kind, input int c);
    evt_t e;
    e.id = id; e.kind = kind; e.cyc = c;
    q.push_back(e);
  endtask

  task automatic pb(input int kind, input int c);
    push(0, kind, c);
    push(1, kind, c);
  endtask

  task automatic check_evt(input int d, input int k);
    int idx;
    idx = -1;
    for (int i = 0; i < q.size(); i++)
      if (idx < 0 && q[i].id == d) idx = i;
    checks++;
    if (idx < 0) begin
      errors++;
      $display("FAIL evt_unexpected dut%0d: got kind %0d at cyc %0d, required no event", d, k, cyc);
    end else begin
      if (q[idx].kind != k || q[idx].cyc != cyc) begin
        errors++;
        $display("FAIL evt dut%0d: got kind %0d at cyc %0d, required kind %0d at cyc %0d",
                 d, k, cyc, q[idx].kind, q[idx].cyc);
      end
      q.delete(idx);
    end
  endtask

  // kinds: 0 note_start, 1 piezo rise, 2 piezo fall
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        if (ns[d])             check_evt(d, 0);
        if (pz[d] && !prev[d]) check_evt(d, 1);
        if (!pz[d] && prev[d]) check_evt(d, 2);
      end
      prev <= pz;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cyc %0d: got %0d, required %0d", nm, cyc, act, exp);
    end
  endtask

  task automatic to(input int c);
    while (cyc < c) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int t0;
    rst = 1'b1; play = 1'b0; pitch = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_piezo%0d", d), int'(pz[d]), 0);
      chk($sformatf("rst_busy%0d", d), int'(busy[d]), 0);
      chk($sformatf("rst_ns%0d", d), int'(ns[d]), 0);
    end
    rst = 1'b0;
    mon_en = 1'b1;
    to(cyc + 2);

    // basic tone, then stop while high
    t0 = cyc; pitch = 32'd20; play = 1'b1;
    pb(0, t0+1); pb(1, t0+21); pb(2, t0+41); pb(1, t0+61); pb(2, t0+81);
    to(t0+2);  chk("run_busy0", int'(busy[0]), 1); chk("run_busy1", int'(busy[1]), 1);
    to(t0+70); play = 1'b0;
    to(t0+75); chk("stoppend_busy0", int'(busy[0]), 1); chk("stoppend_piezo0", int'(pz[0]), 1);
    to(t0+83); chk("stop_busy0", int'(busy[0]), 0); chk("stop_busy1", int'(busy[1]), 0);

    // clamp to MIN, stop while low
    t0 = cyc; pitch = 32'd3; play = 1'b1;
    pb(0, t0+1); pb(1, t0+9); pb(2, t0+17);
    to(t0+20); play = 1'b0;
    to(t0+23); chk("minclamp_idle0", int'(busy[0]), 0); chk("minclamp_idle1", int'(busy[1]), 0);

    // clamp to MAX
    t0 = cyc; pitch = 32'd1000; play = 1'b1;
    pb(0, t0+1); pb(1, t0+301);
    to(t0+310); play = 1'b0;
    pb(2, t0+601);
    to(t0+605); chk("maxclamp_idle0", int'(busy[0]), 0);

    // pitch 0 with play_en stays idle
    pitch = 32'd0; play = 1'b1;
    to(cyc+20);
    chk("silence_busy0", int'(busy[0]), 0); chk("silence_busy1", int'(busy[1]), 0);
    chk("silence_piezo0", int'(pz[0]), 0);
    play = 1'b0;

    // pitch change 20 -> 30 mid half-period, aligned to tick phase
    while (cyc % TICK_P != 0) to(cyc+1);
    t0 = cyc; pitch = 32'd20; play = 1'b1;
    pb(0, t0+1); pb(1, t0+21);
    push(0, 2, t0+41); push(0, 1, t0+71); push(0, 2, t0+101); push(0, 1, t0+131);
    push(0, 2, t0+161); push(0, 1, t0+191); push(0, 2, t0+221);
    push(1, 2, t0+41); push(1, 0, t0+121); push(1, 1, t0+151); push(1, 2, t0+181);
    to(t0+30); pitch = 32'd30;
    to(t0+100);
    chk("gap_busy1", int'(busy[1]), 1); chk("gap_piezo1", int'(pz[1]), 0);
    chk("nogap_piezo0", int'(pz[0]), 1);
    to(t0+195); play = 1'b0;
    to(t0+225); chk("chg_idle0", int'(busy[0]), 0); chk("chg_idle1", int'(busy[1]), 0);

    // drop and re-assert before the boundary: no phase jump
    t0 = cyc; pitch = 32'd20; play = 1'b1;
    pb(0, t0+1); pb(1, t0+21); pb(2, t0+41); pb(1, t0+61);
    pb(2, t0+81); pb(1, t0+101); pb(2, t0+121);
    to(t0+65); play = 1'b0;
    to(t0+67); chk("resume_pend0", int'(busy[0]), 1);
    to(t0+70); play = 1'b1;
    to(t0+125); play = 1'b0;
    to(t0+128); chk("resume_idle0", int'(busy[0]), 0);

    // reset mid-note, play_en held through
    t0 = cyc; pitch = 32'd20; play = 1'b1;
    pb(0, t0+1); pb(1, t0+21); pb(2, t0+26); pb(0, t0+28); pb(1, t0+48); pb(2, t0+68);
    to(t0+25); rst = 1'b1;
    to(t0+26);
    chk("midrst_piezo0", int'(pz[0]), 0); chk("midrst_busy0", int'(busy[0]), 0);
    chk("midrst_busy1", int'(busy[1]), 0);
    to(t0+27); rst = 1'b0;
    to(t0+50); play = 1'b0;
    to(t0+75); chk("final_idle0", int'(busy[0]), 0);

    to(cyc+5);
    foreach (q[i]) begin
      checks++;
      errors++;
      $display("FAIL evt_missing dut%0d: got nothing, required kind %0d at cyc %0d",
               q[i].id, q[i].kind, q[i].cyc);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
